// File: rtl/sha256_msg_sched_if.sv
// sha256_msg_sched_if: block-in / word-out handshake bundle for the SHA-256 message scheduler.
// Block channel: blk_valid, blk_ready, blk_data[511:0] (W0 in bits [511:480]).
// Word channel:  w_valid, w_ready, wt, kt, t_idx, w_last; busy flags an active block.
// master = upstream/round-stage side, slave = the scheduler.
interface sha256_msg_sched_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  wt;
    logic [31:0]  kt;
    logic [5:0]   t_idx;
    logic         w_last;
    logic         busy;
    modport master (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, wt, kt, t_idx, w_last, busy
    );
    modport slave (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, wt, kt, t_idx, w_last, busy
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: streams the 64 (W_t, K_t) pairs of one 512-bit block over a 16-word sliding window.
// Ports: clk, rst_n (async, active low), bus (slave side of sha256_msg_sched_if):
//   block in via blk_valid/blk_ready/blk_data, words out via w_valid/w_ready/wt/kt/t_idx/w_last, busy.
module sha256_msg_sched (
    input  logic              clk,
    input  logic              rst_n,
    sha256_msg_sched_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_w [16];
    logic [5:0]  r_t;
    logic        w_load;
    logic        w_adv;
    logic [31:0] w_new;
    function automatic logic [31:0] f_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction
    function automatic logic [31:0] f_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
    always_comb begin
        w_load      = (r_state == IDLE) && bus.blk_valid;
        w_adv       = (r_state == RUN) && bus.w_ready;
        w_state_nxt = w_load ? RUN : (w_adv && r_t == 6'd63) ? IDLE : r_state;
        // window slot 15 always receives W_{t+16}; past t=47 it is computed but never shown
        w_new       = f_sig1(r_w[14]) + r_w[9] + f_sig0(r_w[1]) + r_w[0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t     <= '0;
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                for (int i = 0; i < 16; i++) r_w[i] <= bus.blk_data[511-32*i -: 32];
                r_t <= '0;
            end else if (w_adv) begin
                for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                r_w[15] <= w_new;
                // 6-bit index wraps 63 -> 0, leaving t cleared for the next block
                r_t     <= r_t + 6'd1;
            end
        end
    end
    assign bus.blk_ready = (r_state == IDLE);
    assign bus.w_valid   = (r_state == RUN);
    assign bus.busy      = (r_state == RUN);
    assign bus.w_last    = (r_state == RUN) && (r_t == 6'd63);
    assign bus.wt        = r_w[0];
    assign bus.kt        = K[r_t];
    assign bus.t_idx     = r_t;
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: randomized self-checking bench against a full 64-word schedule model.
module tb_sha256_msg_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    sha256_msg_sched_if bus();
    sha256_msg_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    wire [73:0] obs = {bus.blk_ready, bus.busy, bus.w_valid, bus.w_last, bus.t_idx, bus.wt, bus.kt};
    wire [41:0] obs_idle = {obs[73:64], obs[31:0]};
    localparam logic [73:0] RST_OBS  = {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'h428a2f98};
    localparam logic [41:0] IDLE_OBS = {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h428a2f98};
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] m_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    logic [31:0]  m_w [64];
    logic [511:0] abc;
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    task automatic build(input logic [511:0] b);
        for (int i = 0; i < 16; i++) m_w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++) m_w[i] = sig1(m_w[i-2]) + m_w[i-7] + sig0(m_w[i-15]) + m_w[i-16];
    endtask
    function automatic logic [511:0] rand_blk();
        logic [511:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
        return r;
    endfunction
    function automatic logic [73:0] exp_run(input int t);
        return {1'b0, 1'b1, 1'b1, t == 63, 6'(t), m_w[t], m_k[t]};
    endfunction
    task automatic load(input logic [511:0] b);
        @(negedge clk);
        bus.blk_data  = b;
        bus.blk_valid = 1'b1;
        @(negedge clk);
        bus.blk_valid = 1'b0;
    endtask
    task automatic test_reset();
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.w_ready   = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== RST_OBS) begin n_fail++; $display("FAIL reset_held got=%h exp=%h", obs, RST_OBS); end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== RST_OBS) begin n_fail++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, obs, RST_OBS); end
        end
    endtask
    task automatic test_abc();
        build(abc);
        bus.w_ready = 1'b1;
        load(abc);
        for (int t = 0; t < 64; t++) begin
            n_tests++;
            if (obs !== exp_run(t)) begin n_fail++; $display("FAIL abc_word t=%0d got=%h exp=%h", t, obs, exp_run(t)); end
            if (t == 15 || t == 16 || t == 17 || t == 63) begin
                n_tests++;
                if (t == 15 && bus.wt !== 32'h00000018) begin n_fail++; $display("FAIL abc_w15 got=%h exp=00000018", bus.wt); end
                if (t == 16 && bus.wt !== 32'h61626380) begin n_fail++; $display("FAIL abc_w16 got=%h exp=61626380", bus.wt); end
                if (t == 17 && bus.wt !== 32'h000F0000) begin n_fail++; $display("FAIL abc_w17 got=%h exp=000f0000", bus.wt); end
                if (t == 63 && {bus.kt, bus.w_last} !== {32'hc67178f2, 1'b1}) begin
                    n_fail++; $display("FAIL abc_k63 got=%h/%b exp=c67178f2/1", bus.kt, bus.w_last);
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (obs_idle !== IDLE_OBS) begin n_fail++; $display("FAIL abc_end got=%h exp=%h", obs_idle, IDLE_OBS); end
    endtask
    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) begin
            logic [511:0] b = (k == 0) ? abc : rand_blk();
            int et = 0;
            build(b);
            load(b);
            for (int c = 0; c < 1000 && et < 64; c++) begin
                n_tests++;
                if (obs !== exp_run(et)) begin n_fail++; $display("FAIL bp_word k=%0d t=%0d got=%h exp=%h", k, et, obs, exp_run(et)); end
                bus.w_ready = 1'($urandom_range(0, 1));
                if (bus.w_ready) et++;
                @(negedge clk);
            end
            n_tests++;
            if (et != 64) begin n_fail++; $display("FAIL bp_timeout k=%0d got=%0d exp=64", k, et); end
            n_tests++;
            if (obs_idle !== IDLE_OBS) begin n_fail++; $display("FAIL bp_end k=%0d got=%h exp=%h", k, obs_idle, IDLE_OBS); end
        end
        bus.w_ready = 1'b1;
    endtask
    task automatic test_back_to_back();
        logic [511:0] b1 = rand_blk();
        logic [511:0] b2 = rand_blk();
        build(b1);
        bus.w_ready = 1'b1;
        @(negedge clk);
        bus.blk_data  = b1;
        bus.blk_valid = 1'b1;
        @(negedge clk);
        bus.blk_data  = b2;
        for (int t = 0; t < 64; t++) begin
            n_tests++;
            if (obs !== exp_run(t)) begin n_fail++; $display("FAIL b2b_first t=%0d got=%h exp=%h", t, obs, exp_run(t)); end
            @(negedge clk);
        end
        n_tests++;
        if (obs_idle !== IDLE_OBS) begin n_fail++; $display("FAIL b2b_gap got=%h exp=%h", obs_idle, IDLE_OBS); end
        build(b2);
        @(negedge clk);
        bus.blk_valid = 1'b0;
        for (int t = 0; t < 64; t++) begin
            n_tests++;
            if (obs !== exp_run(t)) begin n_fail++; $display("FAIL b2b_second t=%0d got=%h exp=%h", t, obs, exp_run(t)); end
            @(negedge clk);
        end
        n_tests++;
        if (obs_idle !== IDLE_OBS) begin n_fail++; $display("FAIL b2b_end got=%h exp=%h", obs_idle, IDLE_OBS); end
    endtask
    task automatic test_reset_mid_block();
        build(abc);
        bus.w_ready = 1'b1;
        load(abc);
        for (int t = 0; t <= 30; t++) begin
            n_tests++;
            if (obs !== exp_run(t)) begin n_fail++; $display("FAIL mid_pre t=%0d got=%h exp=%h", t, obs, exp_run(t)); end
            if (t < 30) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== RST_OBS) begin n_fail++; $display("FAIL mid_async got=%h exp=%h", obs, RST_OBS); end
        bus.blk_data  = rand_blk();
        bus.blk_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== RST_OBS) begin n_fail++; $display("FAIL mid_held c=%0d got=%h exp=%h", c, obs, RST_OBS); end
        end
        rst_n = 1'b1;
        bus.blk_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== RST_OBS) begin n_fail++; $display("FAIL mid_release got=%h exp=%h", obs, RST_OBS); end
        load(abc);
        for (int t = 0; t < 64; t++) begin
            n_tests++;
            if (obs !== exp_run(t)) begin n_fail++; $display("FAIL mid_restart t=%0d got=%h exp=%h", t, obs, exp_run(t)); end
            @(negedge clk);
        end
        n_tests++;
        if (obs_idle !== IDLE_OBS) begin n_fail++; $display("FAIL mid_end got=%h exp=%h", obs_idle, IDLE_OBS); end
    endtask
    task automatic test_all_ones();
        build('1);
        bus.w_ready = 1'b1;
        load('1);
        for (int t = 0; t < 64; t++) begin
            n_tests++;
            if (obs !== exp_run(t)) begin n_fail++; $display("FAIL ones_word t=%0d got=%h exp=%h", t, obs, exp_run(t)); end
            if (t == 16) begin
                n_tests++;
                if (bus.wt !== 32'h203FFFFC) begin n_fail++; $display("FAIL ones_w16 got=%h exp=203ffffc", bus.wt); end
            end
            @(negedge clk);
        end
        n_tests++;
        if (obs_idle !== IDLE_OBS) begin n_fail++; $display("FAIL ones_end got=%h exp=%h", obs_idle, IDLE_OBS); end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        test_reset();
        test_abc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        test_all_ones();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
